sr04_scheduler: RTL and testbench
=================================

SR04_SCHEDULER -- requirements
Module: sr04_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_US, default 60000, giving the minimum idle spacing after each measurement, in 1 us ticks.
REQ-002 The block SHALL have parameter TIMEOUT_US, default 30000, giving the maximum wait for dist_done after a start, in 1 us ticks.
REQ-003 The block SHALL have parameter AUTO_PERIOD_US, default 500000, giving the auto-repeat request period, in 1 us ticks.
REQ-004 The block SHALL have these ports, listed as name, direction, width and meaning:
  clk  in  1  system clock (100 MHz).
  rst  in  1  reset; asynchronous, active-high.
  tick_1us  in  1  one-clk pulse every 1 us.
  btn_req  in  1  debounced button pulse.
  cmd_req  in  1  UART 'd' command pulse.
  auto_en  in  1  level; enables periodic auto requests.
  dist_done  in  1  one-clk pulse from the sensor controller.
  dist_in  in  9  distance in cm, valid with dist_done.
  meas_start  out  1  one-clk start pulse to the sensor controller.
  meas_abort  out  1  one-clk abort pulse on timeout.
  send_start  out  1  one-clk pulse to the distance sender.
  dist_out  out  9  last valid distance, held between measurements.
  busy  out  1  high in every state except IDLE.
  timeout_err  out  1  sticky flag for the last measurement having timed out.
  src_last  out  2  source of the last issued measurement: 0 none, 1 cmd, 2 btn, 3 auto.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, MEASURE, REPORT and GAP.
REQ-006 Each source SHALL have a pending flag, set by its request pulse in any state; repeated requests collapse into a single pending flag.
REQ-007 In IDLE, any set pending flag SHALL move the FSM to ISSUE on the next clk edge, with priority cmd > btn > auto.
REQ-008 In ISSUE, for exactly one clk, the block SHALL assert meas_start, clear the winning pending flag, load src_last and clear the tick counter, then move to MEASURE.
REQ-009 If a request from the winning source arrives in the same cycle its pending flag is cleared, the set SHALL win and the flag stays set.
REQ-010 In MEASURE, the counter SHALL increment on each tick_1us.
REQ-011 In MEASURE, dist_done SHALL latch dist_in into dist_out, clear timeout_err and move the FSM to REPORT.
REQ-012 In MEASURE, when the counter equals TIMEOUT_US-1 and tick_1us is high, the block SHALL set timeout_err, pulse meas_abort for one clk, leave dist_out unchanged and move to GAP.
REQ-013 If dist_done and the timeout condition occur in the same cycle, dist_done SHALL take precedence and no abort is issued.
REQ-014 In REPORT, the block SHALL pulse send_start for one clk, clear the counter and move to GAP.
REQ-015 In GAP, the counter SHALL count ticks, and at GAP_US-1 with tick_1us high the FSM SHALL return to IDLE.
REQ-016 Requests arriving during MEASURE, REPORT or GAP SHALL be held pending and serviced only after GAP completes.
REQ-017 The auto timer SHALL count ticks while auto_en is high.
REQ-018 At AUTO_PERIOD_US-1 with tick_1us high, the auto timer SHALL set auto pending and wrap to 0.
REQ-019 While auto_en is low, the auto timer and the auto pending flag SHALL be held at 0.
REQ-020 A dist_done outside MEASURE SHALL be ignored.
REQ-021 The counter and the auto timer SHALL be 20 bits wide, and every parameter SHALL be below 2^20.
REQ-022 All outputs SHALL be registered, and meas_start SHALL rise one clk after the ISSUE entry decision.

Reset
REQ-023 While rst is high, the block SHALL hold: FSM in IDLE, all pending flags 0, counter and auto timer 0, dist_out 0, src_last 0, and meas_start, meas_abort, send_start, busy and timeout_err all 0.
REQ-024 A reset asserted mid-measurement SHALL abandon the measurement without any abort or send pulse, and release SHALL resume in IDLE.

Structure
REQ-025 The state encodings, the source codes (0 none, 1 cmd, 2 btn, 3 auto) and the default timing constants SHALL reside in the shared package sr04_pkg.
REQ-026 The auto-repeat timer SHALL be implemented as the single sub-module sr04_auto_timer.

Verification (bench uses GAP_US=20, TIMEOUT_US=50, AUTO_PERIOD_US=200)
REQ-027 Scenario single cmd: one cmd_req pulse followed 30 ticks later by dist_done with dist_in=123 SHALL give one meas_start, dist_out=123, one send_start, src_last=1 and busy low 20 ticks after REPORT.
REQ-028 Scenario priority: btn_req and cmd_req in the same cycle SHALL service cmd first (src_last=1), then btn after GAP (src_last=2), giving exactly two meas_start pulses.
REQ-029 Scenario timeout: cmd_req with no dist_done SHALL give meas_abort at tick 50, timeout_err=1, dist_out unchanged and no send_start; the next good measurement SHALL clear timeout_err.
REQ-030 Scenario collapse: three btn_req pulses during MEASURE SHALL result in exactly one extra measurement after GAP.
REQ-031 Scenario auto: with auto_en held high for 1000 ticks and dist_done returned after 10 ticks each time, there SHALL be 5 meas_start pulses with src_last=3; deasserting auto_en SHALL clear auto pending, with no further starts.
REQ-032 Scenario reset: rst asserted during MEASURE SHALL bring all outputs to their reset values immediately, and a dist_done arriving afterwards SHALL be ignored.

Source files
------------

// File: rtl/sr04_pkg.sv
// sr04_pkg: shared state encoding, source codes and timing defaults for the SR04 scheduler
package sr04_pkg;
    localparam int CNT_W              = 20;
    localparam int GAP_US_DEF         = 60000;
    localparam int TIMEOUT_US_DEF     = 30000;
    localparam int AUTO_PERIOD_US_DEF = 500000;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_MEASURE, S_REPORT, S_GAP} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_CMD, SRC_BTN, SRC_AUTO} src_t;
endpackage

// File: rtl/sr04_auto_timer.sv
// sr04_auto_timer: free-running tick counter that fires once per period while enabled
module sr04_auto_timer
    import sr04_pkg::*;
#(
    parameter int PERIOD_US = AUTO_PERIOD_US_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic en_i,
    output logic fire_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    // count ticks, wrap at the period end, hold at zero while disabled
    always_comb begin
        wrap   = tick_i && cnt_q == CNT_W'(PERIOD_US - 1);
        cnt_d  = !en_i ? '0 : wrap ? '0 : tick_i ? cnt_q + 1'b1 : cnt_q;
        fire_o = en_i && wrap;
    end
    // period counter register
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/sr04_scheduler.sv
// sr04_scheduler: arbitrates cmd/btn/auto requests into spaced, time-limited SR04 measurements
module sr04_scheduler
    import sr04_pkg::*;
#(
    parameter int GAP_US         = GAP_US_DEF,
    parameter int TIMEOUT_US     = TIMEOUT_US_DEF,
    parameter int AUTO_PERIOD_US = AUTO_PERIOD_US_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1us,
    input  logic       btn_req,
    input  logic       cmd_req,
    input  logic       auto_en,
    input  logic       dist_done,
    input  logic [8:0] dist_in,
    output logic       meas_start,
    output logic       meas_abort,
    output logic       send_start,
    output logic [8:0] dist_out,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] src_last
);
    state_t           state_q, state_d;
    src_t             src_q, src_d;
    logic [2:0]       pend_q, pend_d, clr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       dist_q, dist_d;
    logic             terr_q, terr_d, abort_d;
    logic             start_q, abort_q, send_q, busy_q;
    logic             auto_fire, tmo, gap_end;

    sr04_auto_timer #(.PERIOD_US(AUTO_PERIOD_US)) u_auto (
        .clk    (clk),
        .rst    (rst),
        .tick_i (tick_1us),
        .en_i   (auto_en),
        .fire_o (auto_fire)
    );

    // next state, shared tick counter, latched result; pending flags are {auto, btn, cmd}
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        terr_d  = terr_q;
        abort_d = 1'b0;
        clr     = '0;
        tmo     = tick_1us && cnt_q == CNT_W'(TIMEOUT_US - 1);
        gap_end = tick_1us && cnt_q == CNT_W'(GAP_US - 1);
        case (state_q)
            S_IDLE:
                if (|pend_q) begin
                    state_d = S_ISSUE;
                    src_d   = pend_q[0] ? SRC_CMD : pend_q[1] ? SRC_BTN : SRC_AUTO;
                end
            S_ISSUE: begin
                state_d = S_MEASURE;
                cnt_d   = '0;
                clr     = src_q == SRC_CMD ? 3'b001 : src_q == SRC_BTN ? 3'b010 : 3'b100;
            end
            S_MEASURE:
                if (dist_done) begin
                    state_d = S_REPORT;
                    dist_d  = dist_in;
                    terr_d  = 1'b0;
                end else if (tmo) begin
                    state_d = S_GAP;
                    terr_d  = 1'b1;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + CNT_W'(tick_1us);
            S_REPORT: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP:
                if (gap_end) state_d = S_IDLE;
                else cnt_d = cnt_q + CNT_W'(tick_1us);
            default: state_d = S_IDLE;
        endcase
        // a new request in the clearing cycle wins over the clear
        pend_d = (pend_q & ~clr) | {auto_fire, btn_req, cmd_req};
        if (!auto_en) pend_d[2] = 1'b0;
    end

    // state/datapath registers; strobes and busy are registered from the next-state decision
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= SRC_NONE;
            pend_q  <= '0;
            cnt_q   <= '0;
            dist_q  <= '0;
            terr_q  <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            dist_q  <= dist_d;
            terr_q  <= terr_d;
            start_q <= state_d == S_ISSUE;
            abort_q <= abort_d;
            send_q  <= state_d == S_REPORT;
            busy_q  <= state_d != S_IDLE;
        end

    assign meas_start  = start_q;
    assign meas_abort  = abort_q;
    assign send_start  = send_q;
    assign dist_out    = dist_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign src_last    = src_q;
endmodule

// File: tb/tb_sr04_scheduler.sv
// tb_sr04_scheduler: directed scenarios plus random traffic against a behavioural scheduler model
module tb_sr04_scheduler;
    localparam int G = 20, TO = 50, AP = 200, DIV = 4;
    localparam int M_IDLE = 0, M_ISSUE = 1, M_MEAS = 2, M_REPORT = 3, M_GAP = 4;

    logic       clk = 1'b0, rst = 1'b1, tick_1us = 1'b0;
    logic       btn_req = 1'b0, cmd_req = 1'b0, auto_en = 1'b0, dist_done = 1'b0;
    logic [8:0] dist_in = '0, dist_out;
    logic       meas_start, meas_abort, send_start, busy, timeout_err;
    logic [1:0] src_last;

    sr04_scheduler #(.GAP_US(G), .TIMEOUT_US(TO), .AUTO_PERIOD_US(AP)) dut (
        .clk(clk), .rst(rst), .tick_1us(tick_1us), .btn_req(btn_req), .cmd_req(cmd_req),
        .auto_en(auto_en), .dist_done(dist_done), .dist_in(dist_in), .meas_start(meas_start),
        .meas_abort(meas_abort), .send_start(send_start), .dist_out(dist_out), .busy(busy),
        .timeout_err(timeout_err), .src_last(src_last)
    );

    always #5 clk = ~clk;

    int div = 0;
    always @(negedge clk) begin
        div = (div + 1) % DIV;
        tick_1us = div == 0;
    end

    // behavioural model: phase, elapsed ticks since phase start, pending set, total auto ticks
    int m_mode = M_IDLE, m_win = 0, m_el = 0, m_auto_n = 0, m_dist = 0, m_src = 0;
    int m_start = 0, m_abort = 0, m_send = 0, m_terr = 0, m_busy = 0;
    bit [2:0] m_pend = '0, m_clr;
    bit m_fire;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_win = 0; m_el = 0; m_auto_n = 0; m_dist = 0; m_src = 0;
            m_start = 0; m_abort = 0; m_send = 0; m_terr = 0; m_busy = 0; m_pend = '0;
        end else begin
            m_fire = auto_en && tick_1us && (m_auto_n % AP == AP - 1);
            m_auto_n = auto_en ? m_auto_n + int'(tick_1us) : 0;
            m_clr = '0; m_start = 0; m_abort = 0; m_send = 0;
            case (m_mode)
                M_IDLE: if (m_pend != 0) begin
                    m_win = m_pend[0] ? 1 : m_pend[1] ? 2 : 3;
                    m_src = m_win; m_mode = M_ISSUE; m_start = 1;
                end
                M_ISSUE: begin m_clr[m_win-1] = 1'b1; m_el = 0; m_mode = M_MEAS; end
                M_MEAS: if (dist_done) begin
                    m_dist = int'(dist_in); m_terr = 0; m_mode = M_REPORT; m_send = 1;
                end else if (tick_1us && m_el == TO - 1) begin
                    m_terr = 1; m_abort = 1; m_el = 0; m_mode = M_GAP;
                end else m_el += int'(tick_1us);
                M_REPORT: begin m_el = 0; m_mode = M_GAP; end
                default: if (tick_1us && m_el == G - 1) m_mode = M_IDLE; else m_el += int'(tick_1us);
            endcase
            m_pend[0] = (m_pend[0] & ~m_clr[0]) | cmd_req;
            m_pend[1] = (m_pend[1] & ~m_clr[1]) | btn_req;
            m_pend[2] = auto_en && ((m_pend[2] & ~m_clr[2]) | m_fire);
            m_busy = int'(m_mode != M_IDLE);
        end
    end

    int n_cmp = 0, n_bad = 0;
    int n_start = 0, n_abort = 0, n_send = 0, n_src3 = 0;
    int srcs[$];
    bit chk_en = 0, resp_en = 0;
    int resp_ticks = 10, resp_val = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_counts();
        n_start = 0; n_abort = 0; n_send = 0; n_src3 = 0;
        srcs.delete();
    endtask

    task automatic pulse(input int w);
        if (w == 0) cmd_req = 1'b1; else if (w == 1) btn_req = 1'b1; else dist_done = 1'b1;
        @(negedge clk);
        if (w == 0) cmd_req = 1'b0; else if (w == 1) btn_req = 1'b0; else dist_done = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0, k = 0;
        while (q < 10 && k < 3000) begin
            @(negedge clk);
            q = busy ? 0 : q + 1;
            k++;
        end
        check({tag, "_quiet"}, 32'(q >= 10), 1);
    endtask

    task automatic wait_start(input string tag, input int n);
        int k = 0;
        while (n_start < n && k < 500) begin @(negedge clk); k++; end
        check({tag, "_start_seen"}, 32'(n_start >= n), 1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    check("cyc_start", 32'(meas_start), m_start);
                    check("cyc_abort", 32'(meas_abort), m_abort);
                    check("cyc_send", 32'(send_start), m_send);
                    check("cyc_dist", 32'(dist_out), m_dist);
                    check("cyc_busy", 32'(busy), m_busy);
                    check("cyc_terr", 32'(timeout_err), m_terr);
                    check("cyc_src", 32'(src_last), m_src);
                end
                n_start += int'(meas_start);
                n_abort += int'(meas_abort);
                n_send  += int'(send_start);
                if (meas_start) begin
                    srcs.push_back(int'(src_last));
                    n_src3 += int'(src_last == 2'd3);
                end
            end
            forever begin
                @(negedge clk);
                if (resp_en && meas_start) begin
                    repeat (resp_ticks * DIV) @(negedge clk);
                    dist_in = 9'(resp_val);
                    dist_done = 1'b1;
                    @(negedge clk);
                    dist_done = 1'b0;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_start", 32'(meas_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dist", 32'(dist_out), 0);
        check("rst_src", 32'(src_last), 0);
        check("rst_terr", 32'(timeout_err), 0);
        rst = 1'b0;
        chk_en = 1;
        repeat (4) @(negedge clk);

        // single cmd measurement
        resp_en = 1; resp_ticks = 30; resp_val = 123;
        clr_counts();
        pulse(0);
        wait_quiet("s1");
        check("s1_starts", n_start, 1);
        check("s1_sends", n_send, 1);
        check("s1_dist", 32'(dist_out), 123);
        check("s1_src", 32'(src_last), 1);
        check("s1_aborts", n_abort, 0);

        // simultaneous cmd and btn: cmd served first
        resp_ticks = 5; resp_val = 77;
        clr_counts();
        cmd_req = 1'b1; btn_req = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0; btn_req = 1'b0;
        wait_quiet("s2");
        check("s2_starts", n_start, 2);
        check("s2_first_src", srcs.size() > 0 ? srcs[0] : -1, 1);
        check("s2_second_src", srcs.size() > 1 ? srcs[1] : -1, 2);

        // timeout, then a good measurement clears the flag
        resp_en = 0;
        clr_counts();
        pulse(0);
        wait_quiet("s3");
        check("s3_aborts", n_abort, 1);
        check("s3_terr", 32'(timeout_err), 1);
        check("s3_dist_held", 32'(dist_out), 77);
        check("s3_sends", n_send, 0);
        resp_en = 1; resp_ticks = 8; resp_val = 200;
        pulse(0);
        wait_quiet("s3b");
        check("s3_terr_clr", 32'(timeout_err), 0);
        check("s3_dist_new", 32'(dist_out), 200);

        // repeated btn during MEASURE collapses into one extra measurement
        resp_ticks = 10; resp_val = 33;
        clr_counts();
        pulse(0);
        wait_start("s4", 1);
        repeat (3) begin pulse(1); @(negedge clk); end
        wait_quiet("s4");
        check("s4_starts", n_start, 2);
        check("s4_second_src", srcs.size() > 1 ? srcs[1] : -1, 2);

        // auto repeat for 1000 ticks
        resp_ticks = 10; resp_val = 44;
        clr_counts();
        auto_en = 1'b1;
        repeat (1000 * DIV + 2) @(negedge clk);
        auto_en = 1'b0;
        repeat (300 * DIV) @(negedge clk);
        check("s5_starts", n_start, 5);
        check("s5_auto_srcs", n_src3, 5);
        check("s5_busy", 32'(busy), 0);

        // reset during MEASURE, late dist_done ignored
        resp_en = 0;
        clr_counts();
        pulse(0);
        repeat (5 * DIV) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("s6_start", 32'(meas_start), 0);
        check("s6_abort", 32'(meas_abort), 0);
        check("s6_send", 32'(send_start), 0);
        check("s6_dist", 32'(dist_out), 0);
        check("s6_busy", 32'(busy), 0);
        check("s6_terr", 32'(timeout_err), 0);
        check("s6_src", 32'(src_last), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dist_in = 9'd99;
        pulse(2);
        repeat (60 * DIV) @(negedge clk);
        check("s6_dist_ignored", 32'(dist_out), 0);
        check("s6_idle", 32'(busy), 0);
        check("s6_no_send", n_send, 0);
        check("s6_no_abort", n_abort, 0);

        // random traffic, including stray dist_done outside MEASURE
        begin
            int p_done = 3;
            for (int i = 0; i < 6000; i++) begin
                @(negedge clk);
                if (i % 500 == 0) p_done = $urandom_range(0, 1) ? 3 : 0;
                cmd_req   = $urandom_range(0, 199) < 2;
                btn_req   = $urandom_range(0, 199) < 2;
                dist_done = $urandom_range(0, 99) < p_done;
                dist_in   = 9'($urandom_range(0, 511));
                if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
            end
        end
        cmd_req = 1'b0; btn_req = 1'b0; dist_done = 1'b0; auto_en = 1'b0;
        wait_quiet("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
